// File: rtl/ram2p_pkg.sv
// Shared sizing defaults for the two-port RAM FIFO controller.
package ram2p_pkg;
    localparam int DEFAULT_DEPTH      = 8;
    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int DEFAULT_DATA_WIDTH = 256;
    // level counts RAM words + one in-flight read + two buffered words
    localparam int LEVEL_WIDTH        = DEFAULT_ADDR_WIDTH + 2;
endpackage

// File: rtl/out_skid_buf2.sv
// Two-entry output buffer (head + skid) that absorbs the RAM read latency.
// outValid and outData are registered; readData never reaches them combinationally.
module out_skid_buf2
    import ram2p_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clockCore,
    input  logic                  resetCore,
    input  logic                  flush,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] captureData,
    input  logic                  pop,
    output logic                  outValid,
    output logic [DATA_WIDTH-1:0] outData,
    output logic [1:0]            bufCount
);

    logic [DATA_WIDTH-1:0] skid;
    logic [1:0]            nextCount;

    // Occupancy after this cycle's capture/pop
    always_comb begin
        nextCount = bufCount;
        if (capture && !pop)
            nextCount = bufCount + 2'd1;
        else if (!capture && pop)
            nextCount = bufCount - 2'd1;
    end

    // Head/skid update: on pop the skid moves forward, else the new word lands at the tail
    always_ff @(posedge clockCore or posedge resetCore) begin
        if (resetCore) begin
            outData  <= '0;
            skid     <= '0;
            bufCount <= '0;
            outValid <= 1'b0;
        end else if (flush) begin
            // a capture in this cycle belongs to the flushed stream and is dropped
            outData  <= '0;
            skid     <= '0;
            bufCount <= '0;
            outValid <= 1'b0;
        end else begin
            bufCount <= nextCount;
            outValid <= (nextCount != 2'd0);
            if (pop && bufCount == 2'd2) begin
                outData <= skid;
                if (capture)
                    skid <= captureData;
            end else if (pop) begin
                if (capture)
                    outData <= captureData;
            end else if (capture) begin
                if (bufCount == 2'd0)
                    outData <= captureData;
                else
                    skid <= captureData;
            end
        end
    end

endmodule

// File: rtl/ram2p_fifo_ctrl.sv
// First-word-fall-through FIFO sequencer around an external two-port RAM.
// Owns write/read pointers, RAM occupancy, read issue and the output buffer.
module ram2p_fifo_ctrl
    import ram2p_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clockCore,
    input  logic                  resetCore,
    input  logic                  flush,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DATA_WIDTH-1:0] inData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] outData,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  enableWrite,
    output logic [ADDR_WIDTH-1:0] addressWrite,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  enableRead,
    output logic [ADDR_WIDTH-1:0] addressRead,
    input  logic [DATA_WIDTH-1:0] readData
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic [ADDR_WIDTH:0]   ramCount;
    logic                  pendingRead;
    logic [1:0]            bufCount;
    logic                  push;
    logic                  pop;
    logic                  issue;

    // Full/empty come from ramCount only, so pointer wrap needs no special case
    assign inReady = !resetCore && (ramCount < DEPTH_CNT);
    assign push    = inValid && inReady && !flush;
    assign pop     = outValid && outReady;

    // Read only when the buffer still has room once the in-flight word and this pop settle.
    // A word pushed this cycle is not yet in ramCount, so it is never read at its write address.
    assign issue = !flush && (ramCount != '0) &&
                   (({1'b0, bufCount} + {2'b00, pendingRead}) < (3'd2 + {2'b00, pop}));

    assign enableWrite  = push;
    assign addressWrite = wrPtr;
    assign writeData    = inData;
    assign enableRead   = issue;
    assign addressRead  = rdPtr;

    assign level = (ADDR_WIDTH+2)'(ramCount) + (ADDR_WIDTH+2)'(pendingRead) +
                   (ADDR_WIDTH+2)'(bufCount);

    // Pointer, occupancy and in-flight tracking; flush wins over push and issue
    always_ff @(posedge clockCore or posedge resetCore) begin
        if (resetCore) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            ramCount    <= '0;
            pendingRead <= 1'b0;
        end else if (flush) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            ramCount    <= '0;
            pendingRead <= 1'b0;
        end else begin
            if (push)
                wrPtr <= wrPtr + ADDR_WIDTH'(1);
            if (issue)
                rdPtr <= rdPtr + ADDR_WIDTH'(1);
            pendingRead <= issue;
            case ({push, issue})
                2'b10:   ramCount <= ramCount + (ADDR_WIDTH+1)'(1);
                2'b01:   ramCount <= ramCount - (ADDR_WIDTH+1)'(1);
                default: ramCount <= ramCount;
            endcase
        end
    end

    out_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) uBuf (
        .clockCore   (clockCore),
        .resetCore   (resetCore),
        .flush       (flush),
        .capture     (pendingRead),
        .captureData (readData),
        .pop         (pop),
        .outValid    (outValid),
        .outData     (outData),
        .bufCount    (bufCount)
    );

endmodule

// File: doc/ram2p_fifo_ctrl.md
Name: ram2p_fifo_ctrl

Overview:
- Sequencer that turns the 8-deep x 256-bit two-port RAM into a first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Sits between a DMA payload producer (TLP receive path) and a consumer (descriptor/payload engine).
- Drives the RAM's read/write enables and addresses, and owns a 2-entry output buffer that hides the RAM's 1-cycle read latency so that sustained throughput is 1 word per clock.

Parameters:
- DEPTH, 8, number of RAM entries; must be a power of 2.
- ADDR_WIDTH, 3, equal to log2(DEPTH).
- DATA_WIDTH, 256, word width.

Ports:
- clockCore  in  1  core clock; all logic is rising-edge.
- resetCore  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all FIFO state.
- inValid  in  1  producer has a word.
- inReady  out  1  controller accepts the word this cycle.
- inData  in  DATA_WIDTH  producer word.
- outValid  out  1  outData holds a word.
- outReady  in  1  consumer takes the word this cycle.
- outData  out  DATA_WIDTH  head word.
- level  out  ADDR_WIDTH+2  words held: in RAM, plus in flight, plus buffered.
- enableWrite  out  1  RAM write enable.
- addressWrite  out  ADDR_WIDTH  RAM write address.
- writeData  out  DATA_WIDTH  RAM write data.
- enableRead  out  1  RAM read enable.
- addressRead  out  ADDR_WIDTH  RAM read address.
- readData  in  DATA_WIDTH  RAM read data; valid the cycle after enableRead.

Behaviour:
- Reset (async assert; deassert is synchronised by the integrator) and flush (synchronous) force every register to 0:
  - wrPtr, rdPtr, ramCount, pendingRead, bufCount.
  - outValid=0, inReady=0 during reset, enableRead=0, enableWrite=0, level=0.
- Flush has priority over push/pop/read in the same cycle. A read in flight during flush is discarded: its readData is not captured.
- Push:
  - inReady = (ramCount < DEPTH), a combinational function of registered state.
  - push = inValid & inReady.
  - On push: enableWrite=1, addressWrite=wrPtr, writeData=inData (all combinational). wrPtr increments mod DEPTH.
- Read issue:
  - pop = outValid & outReady.
  - issue = (ramCount != 0) & (bufCount + pendingRead - pop < 2).
  - On issue: enableRead=1, addressRead=rdPtr (combinational). rdPtr increments mod DEPTH; pendingRead is set to 1 for the next cycle.
- ramCount next value = ramCount + push - issue.
  - A push into an empty RAM cannot be read in the same cycle; it is read the next cycle. This avoids same-address read-during-write.
- Capture: when pendingRead=1, readData is written into the output buffer at the tail. The buffer is a 2-entry FIFO (head/skid registers).
  - Capture and pop in the same cycle are legal. Head is taken from the skid if present, otherwise directly from readData.
- outValid = (bufCount != 0); outData = head register. Both are registered, with no combinational path from readData.
- Latency: a push at cycle T gives outValid=1 at T+3 when the FIFO was empty. In steady state, with push and pop every cycle, there are no bubbles.
- Capacity is DEPTH+2 total. level = ramCount + pendingRead + bufCount, range 0..DEPTH+2.
- Overflow is impossible by construction (the issue rule guarantees the buffer never exceeds 2). A push while full is simply not accepted.
- outData is held stable while outValid=1 and outReady=0. Assertions in the bench check this, plus: bufCount<=2, ramCount<=DEPTH, no enableRead when ramCount=0.
- Pointer wrap: 7 -> 0 with no special case. Full/empty are distinguished by ramCount, not by pointer compare.

Decomposition:
- Shared package ram2p_pkg holds:
  - DEPTH, ADDR_WIDTH, DATA_WIDTH defaults.
  - The level width constant.
- One sub-module, out_skid_buf2: the 2-entry output buffer with capture, pop, bufCount, head and outValid.
- The top level holds pointers, counts, the issue logic and the RAM port drive. It is bench-connected to the existing 2-port RAM wrapper.

Test Plan:
- Reset mid-stream: fill 5 words, assert resetCore -> level=0, outValid=0, enableRead/enableWrite=0 immediately. After release, inReady=1.
- Single word: push 0xA5..A5 at T -> enableRead at T+1, outValid=1 with outData=0xA5..A5 at T+3, level=1 from T+1.
- Fill to full with outReady=0: push words 0..11 -> 10 accepted (8 RAM + 2 buffer); inReady=0 after the 8th RAM write with reads drained; level=10. Then drain -> out order 0..9, level returns to 0.
- Streaming: inValid=1 and outReady=1 for 40 cycles with an incrementing pattern -> after the initial 3-cycle latency one word out per cycle, in order, with pointer wrap exercised 5 times.
- Random backpressure: 30% random outReady low and 30% random inValid low for 2000 cycles -> scoreboard matches, outData stable while stalled, no assertion fires.
- Flush with a read in flight: issue read, assert flush the same cycle as pendingRead=1 -> level=0 next cycle, the stale readData is not presented, and a subsequent push of 0x1 comes out first.
